// File: rtl/fsm_reg_array.sv
`default_nettype none
// ============================================================================
// Module   : fsm_reg_array
// Purpose  : WIDTH x DEPTH register array sequenced by a small FSM.
//            After reset a hardware sweep writes INIT_VAL to every entry.
//            Reads and writes are then served over a valid/ready command
//            port, and reads return data over a back-pressured response
//            port. A watch port mirrors one entry and flags when a command
//            write changes it.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous reset, active low
//   cmd_valid      in   command offered
//   cmd_ready      out  command accepted this cycle (IDLE only)
//   cmd_write      in   1 = write, 0 = read
//   cmd_addr       in   [ADDR_W-1:0] entry index
//   cmd_data       in   [WIDTH-1:0]  write data
//   rsp_valid      out  read data available
//   rsp_ready      in   consumer takes read data
//   rsp_data       out  [WIDTH-1:0]  read data
//   watch_data     out  [WIDTH-1:0]  live contents of entry WATCH_IDX
//   watch_changed  out  one-cycle pulse after a write that changed WATCH_IDX
//   init_done      out  init sweep complete
// ----------------------------------------------------------------------------
// Build option:
//   FSM_REG_ARRAY_TRACE_EN - when defined, accepted and dropped writes are
//                            printed in simulation. Hardware is unchanged.
// ============================================================================
module fsm_reg_array #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 4,
  parameter int unsigned      ADDR_W    = 2,
  parameter logic [WIDTH-1:0] INIT_VAL  = '0,
  parameter int unsigned      WATCH_IDX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [WIDTH-1:0]  cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic [WIDTH-1:0]  watch_data,
  output logic              watch_changed,
  output logic              init_done
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // DEPTH held one bit wider than the address so the range compare is exact
  // even when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_WATCH = ADDR_W'(WATCH_IDX);

  state_t             r_state;
  logic [ADDR_W-1:0]  r_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];

  logic               w_accept;
  logic               w_in_range;
  logic               w_cmd_wr;
  logic [WIDTH-1:0]   w_rd_data;
  logic               w_mem_we;
  logic [ADDR_W-1:0]  w_mem_addr;
  logic [WIDTH-1:0]   w_mem_wdata;

  // cmd_ready is only ever high in IDLE, so an accept implies IDLE.
  assign w_accept   = cmd_valid & cmd_ready;
  assign w_in_range = ({1'b0, cmd_addr} < c_DEPTH);
  assign w_cmd_wr   = w_accept & cmd_write & w_in_range;
  // Out-of-range reads return zero; no aliasing onto real entries.
  assign w_rd_data  = w_in_range ? r_mem[cmd_addr] : '0;

  // One write port shared between the init sweep and command writes.
  assign w_mem_we    = (r_state == S_INIT) | w_cmd_wr;
  assign w_mem_addr  = (r_state == S_INIT) ? r_ptr : cmd_addr;
  assign w_mem_wdata = (r_state == S_INIT) ? INIT_VAL : cmd_data;

  assign watch_data  = r_mem[c_WATCH];

  // Storage carries no reset: contents are defined by the sweep instead.
  always_ff @(posedge clk) begin
    if (reset && w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_INIT;
      r_ptr         <= '0;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      watch_changed <= 1'b0;
      init_done     <= 1'b0;
    end else begin
      watch_changed <= 1'b0;
      case (r_state)
        S_INIT: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == c_LAST) begin
            r_state   <= S_IDLE;
            cmd_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end

        S_IDLE: begin
          if (w_accept) begin
            if (cmd_write) begin
              // Compare against the pre-write value still held this cycle.
              if (w_in_range && (cmd_addr == c_WATCH) &&
                  (cmd_data != r_mem[c_WATCH])) begin
                watch_changed <= 1'b1;
              end
`ifdef FSM_REG_ARRAY_TRACE_EN
              if (w_in_range) begin
                $display("fsm_reg_array[%0d] = %h", cmd_addr, cmd_data);
              end else begin
                $display("fsm_reg_array drop %0d", cmd_addr);
              end
`endif
            end else begin
              rsp_data  <= w_rd_data;
              rsp_valid <= 1'b1;
              cmd_ready <= 1'b0;
              r_state   <= S_RESP;
            end
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end

        default: begin
          r_state   <= S_INIT;
          r_ptr     <= '0;
          cmd_ready <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fsm_reg_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_reg_array
// Purpose  : Self-checking bench for fsm_reg_array. Index 0 is a default
//            instance (DEPTH=4, INIT_VAL=0); index 1 is DEPTH=5, ADDR_W=3,
//            INIT_VAL=0xC3 for the non-power-of-two range cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_reg_array;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n         [2];
  logic        cmd_valid     [2];
  logic        cmd_write     [2];
  logic [2:0]  cmd_addr      [2];
  logic [31:0] cmd_data      [2];
  logic        rsp_ready     [2];
  logic        cmd_ready     [2];
  logic        rsp_valid     [2];
  logic [31:0] rsp_data      [2];
  logic [31:0] watch_data    [2];
  logic        watch_changed [2];
  logic        init_done     [2];

  fsm_reg_array dut_a (
    .clk           (clk),
    .reset         (rst_n[0]),
    .cmd_valid     (cmd_valid[0]),
    .cmd_ready     (cmd_ready[0]),
    .cmd_write     (cmd_write[0]),
    .cmd_addr      (cmd_addr[0][1:0]),
    .cmd_data      (cmd_data[0]),
    .rsp_valid     (rsp_valid[0]),
    .rsp_ready     (rsp_ready[0]),
    .rsp_data      (rsp_data[0]),
    .watch_data    (watch_data[0]),
    .watch_changed (watch_changed[0]),
    .init_done     (init_done[0])
  );

  fsm_reg_array #(
    .WIDTH     (32),
    .DEPTH     (5),
    .ADDR_W    (3),
    .INIT_VAL  (32'h0000_00C3),
    .WATCH_IDX (3)
  ) dut_b (
    .clk           (clk),
    .reset         (rst_n[1]),
    .cmd_valid     (cmd_valid[1]),
    .cmd_ready     (cmd_ready[1]),
    .cmd_write     (cmd_write[1]),
    .cmd_addr      (cmd_addr[1]),
    .cmd_data      (cmd_data[1]),
    .rsp_valid     (rsp_valid[1]),
    .rsp_ready     (rsp_ready[1]),
    .rsp_data      (rsp_data[1]),
    .watch_data    (watch_data[1]),
    .watch_changed (watch_changed[1]),
    .init_done     (init_done[1])
  );

  int n_vec  = 0;
  int n_bad  = 0;
  int pulses = 0;

  // Count watch_changed pulses on the default instance.
  always @(posedge clk) begin
    #1;
    if (watch_changed[0] === 1'b1) pulses++;
  end

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_data;  // watch_data after a write, rsp_data for a read
    logic        exp_chg;   // expected watch_changed after a write
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Leaves cmd_valid high so back-to-back writes have no bubble.
  task automatic do_write(input int s, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    cmd_valid[s] = 1'b1;
    cmd_write[s] = 1'b1;
    cmd_addr[s]  = a;
    cmd_data[s]  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle(input int s);
    @(negedge clk);
    cmd_valid[s] = 1'b0;
    cmd_write[s] = 1'b0;
  endtask

  task automatic do_read(input int s, input logic [2:0] a, input logic [31:0] exp,
                         input string name);
    @(negedge clk);
    cmd_valid[s] = 1'b1;
    cmd_write[s] = 1'b0;
    cmd_addr[s]  = a;
    @(posedge clk);
    #1;
    chk({name, " rsp_valid"}, 32'(rsp_valid[s]), 32'd1);
    chk({name, " rsp_data"},  rsp_data[s],        exp);
    @(negedge clk);
    cmd_valid[s] = 1'b0;
    rsp_ready[s] = 1'b1;
    @(posedge clk);
    #1;
    chk({name, " rsp_valid clear"}, 32'(rsp_valid[s]), 32'd0);
    chk({name, " cmd_ready back"},  32'(cmd_ready[s]), 32'd1);
    @(negedge clk);
    rsp_ready[s] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst_n[s]     = 1'b0;
      cmd_valid[s] = 1'b0;
      cmd_write[s] = 1'b0;
      cmd_addr[s]  = '0;
      cmd_data[s]  = '0;
      rsp_ready[s] = 1'b0;
    end

    //             wr    addr  data           exp            chg
    tbl[0]  = '{1'b0, 3'd3, 32'h0,         32'h0,         1'b0};
    tbl[1]  = '{1'b1, 3'd3, 32'h123,       32'h123,       1'b1};
    tbl[2]  = '{1'b1, 3'd3, 32'hABC,       32'hABC,       1'b1};
    tbl[3]  = '{1'b1, 3'd3, 32'hABC,       32'hABC,       1'b0};
    tbl[4]  = '{1'b1, 3'd1, 32'h55,        32'hABC,       1'b0};
    tbl[5]  = '{1'b0, 3'd1, 32'h0,         32'h55,        1'b0};
    tbl[6]  = '{1'b0, 3'd3, 32'h0,         32'hABC,       1'b0};
    tbl[7]  = '{1'b1, 3'd0, 32'hDEADBEEF,  32'hABC,       1'b0};
    tbl[8]  = '{1'b0, 3'd0, 32'h0,         32'hDEADBEEF,  1'b0};
    tbl[9]  = '{1'b0, 3'd2, 32'h0,         32'h0,         1'b0};
    tbl[10] = '{1'b1, 3'd3, 32'h0,         32'h0,         1'b1};
    tbl[11] = '{1'b0, 3'd3, 32'h0,         32'h0,         1'b0};

    // Reset values while reset is held.
    #2;
    chk("reset cmd_ready",     32'(cmd_ready[0]),     32'd0);
    chk("reset rsp_valid",     32'(rsp_valid[0]),     32'd0);
    chk("reset rsp_data",      rsp_data[0],           32'd0);
    chk("reset watch_changed", 32'(watch_changed[0]), 32'd0);
    chk("reset init_done",     32'(init_done[0]),     32'd0);

    // Init sweep: 4 edges for the default instance, 5 for DEPTH=5.
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("init_done A edge %0d", i), 32'(init_done[0]), 32'(i >= 4));
      chk($sformatf("cmd_ready A edge %0d", i), 32'(cmd_ready[0]), 32'(i >= 4));
      chk($sformatf("init_done B edge %0d", i), 32'(init_done[1]), 32'(i >= 5));
    end

    // Table of single commands on the default instance.
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].wr) begin
        do_write(0, tbl[i].addr, tbl[i].data);
        chk($sformatf("vec%0d watch_data", i),    watch_data[0],           tbl[i].exp_data);
        chk($sformatf("vec%0d watch_changed", i), 32'(watch_changed[0]),   32'(tbl[i].exp_chg));
        chk($sformatf("vec%0d cmd_ready", i),     32'(cmd_ready[0]),       32'd1);
      end else begin
        do_read(0, tbl[i].addr, tbl[i].exp_data, $sformatf("vec%0d read", i));
      end
    end
    chk("watch_changed pulse count", 32'(pulses), 32'd3);

    // Back-pressure: hold rsp_ready low 3 cycles while a write is offered
    // that must be ignored (cmd_ready low in RESP).
    @(negedge clk);
    cmd_valid[0] = 1'b1;
    cmd_write[0] = 1'b0;
    cmd_addr[0]  = 3'd1;
    @(posedge clk);
    #1;
    @(negedge clk);
    cmd_write[0] = 1'b1;
    cmd_addr[0]  = 3'd3;
    cmd_data[0]  = 32'h777;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d rsp_valid", i), 32'(rsp_valid[0]), 32'd1);
      chk($sformatf("bp%0d rsp_data", i),  rsp_data[0],       32'h55);
      chk($sformatf("bp%0d cmd_ready", i), 32'(cmd_ready[0]), 32'd0);
    end
    chk("bp ignored write", watch_data[0], 32'h0);
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("bp release cmd_ready", 32'(cmd_ready[0]), 32'd1);
    @(negedge clk);
    rsp_ready[0] = 1'b0;

    // Reset during RESP: pending response discarded at once, sweep re-runs.
    do_write(0, 3'd2, 32'hCAFE);
    do_read(0, 3'd2, 32'hCAFE, "pre-reset read");
    @(negedge clk);
    cmd_valid[0] = 1'b1;
    cmd_write[0] = 1'b0;
    cmd_addr[0]  = 3'd1;
    @(posedge clk);
    #1;
    chk("in RESP rsp_valid", 32'(rsp_valid[0]), 32'd1);
    #2;
    rst_n[0] = 1'b0;
    #1;
    chk("async reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("async reset rsp_data",  rsp_data[0],       32'd0);
    chk("async reset init_done", 32'(init_done[0]), 32'd0);
    cmd_valid[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("re-init_done edge %0d", i), 32'(init_done[0]), 32'(i >= 4));
    end
    for (int a = 0; a < 4; a++) begin
      do_read(0, 3'(a), 32'h0, $sformatf("re-init read %0d", a));
    end

    // DEPTH=5 instance: out-of-range writes dropped, reads return 0.
    do_write(1, 3'd6, 32'hFF);
    chk("B drop watch_changed", 32'(watch_changed[1]), 32'd0);
    go_idle(1);
    do_read(1, 3'd6, 32'h0,  "B read 6");
    do_read(1, 3'd4, 32'hC3, "B read 4");
    do_read(1, 3'd2, 32'hC3, "B read 2");
    do_read(1, 3'd1, 32'hC3, "B read 1");
    do_read(1, 3'd5, 32'h0,  "B read 5");
    do_write(1, 3'd4, 32'h11);
    do_write(1, 3'd3, 32'h42);
    chk("B watch_data",    watch_data[1],           32'h42);
    chk("B watch_changed", 32'(watch_changed[1]),   32'd1);
    go_idle(1);
    do_read(1, 3'd4, 32'h11, "B read 4 after write");
    do_read(1, 3'd7, 32'h0,  "B read 7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
